// File: rtl/control_pkg.sv
// Shared opcode and control-field encodings for the single-cycle MIPS control path.
// The datapath write-back and store-width muxes use the same constants.
package control_pkg;

    localparam int unsigned OP_W   = 6;
    localparam int unsigned CTRL_W = 15;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_LB    = 6'b100000;
    localparam logic [OP_W-1:0] OP_LBU   = 6'b100100;
    localparam logic [OP_W-1:0] OP_LH    = 6'b100001;
    localparam logic [OP_W-1:0] OP_LHU   = 6'b100101;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_SB    = 6'b101000;
    localparam logic [OP_W-1:0] OP_SH    = 6'b101001;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUSRC_REG = 2'b00;
    localparam logic [1:0] ALUSRC_IMM = 2'b01;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] WB_ALU = 3'b000;
    localparam logic [2:0] WB_LW  = 3'b001;
    localparam logic [2:0] WB_LB  = 3'b010;
    localparam logic [2:0] WB_LBU = 3'b011;
    localparam logic [2:0] WB_LH  = 3'b100;
    localparam logic [2:0] WB_LHU = 3'b101;
    localparam logic [2:0] WB_LUI = 3'b110;

    localparam logic [1:0] ST_WORD = 2'b00;
    localparam logic [1:0] ST_BYTE = 2'b01;
    localparam logic [1:0] ST_HALF = 2'b10;

    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       regdest;
        logic       branch;
        logic       jump;
        logic [1:0] alusrc;
        logic [1:0] aluop;
        logic [2:0] memtoreg;
        logic [1:0] regtomem;
    } ctrl_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode-to-control-word decoder; unknown opcodes decode to an all-zero NOP.
module control_decode
    import control_pkg::*;
(
    input  logic [OP_W-1:0] op_i,
    output ctrl_t           ctrl_c_o
);

    always_comb begin
        ctrl_c_o = '0;
        case (op_i)
            OP_RTYPE: begin
                ctrl_c_o.regwrite = 1'b1;
                ctrl_c_o.regdest  = 1'b1;
                ctrl_c_o.alusrc   = ALUSRC_REG;
                ctrl_c_o.aluop    = ALUOP_FUNCT;
                ctrl_c_o.memtoreg = WB_ALU;
            end
            OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU: begin
                ctrl_c_o.memread  = 1'b1;
                ctrl_c_o.regwrite = 1'b1;
                ctrl_c_o.alusrc   = ALUSRC_IMM;
                ctrl_c_o.aluop    = ALUOP_ADD;
                case (op_i)
                    OP_LB:   ctrl_c_o.memtoreg = WB_LB;
                    OP_LBU:  ctrl_c_o.memtoreg = WB_LBU;
                    OP_LH:   ctrl_c_o.memtoreg = WB_LH;
                    OP_LHU:  ctrl_c_o.memtoreg = WB_LHU;
                    default: ctrl_c_o.memtoreg = WB_LW;
                endcase
            end
            OP_LUI: begin
                ctrl_c_o.regwrite = 1'b1;
                ctrl_c_o.memtoreg = WB_LUI;
            end
            OP_SW, OP_SB, OP_SH: begin
                ctrl_c_o.memwrite = 1'b1;
                ctrl_c_o.alusrc   = ALUSRC_IMM;
                ctrl_c_o.aluop    = ALUOP_ADD;
                case (op_i)
                    OP_SB:   ctrl_c_o.regtomem = ST_BYTE;
                    OP_SH:   ctrl_c_o.regtomem = ST_HALF;
                    default: ctrl_c_o.regtomem = ST_WORD;
                endcase
            end
            OP_BEQ: begin
                ctrl_c_o.branch = 1'b1;
                ctrl_c_o.aluop  = ALUOP_SUB;
            end
            OP_J: begin
                ctrl_c_o.jump = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control.sv
// Main MIPS control unit: decoded control word held in a register with synchronous reset to NOP.
module control
    import control_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    output logic            memread,
    output logic            memwrite,
    output logic            regwrite,
    output logic            regdest,
    output logic            branch,
    output logic            jump,
    output logic            alusrc1,
    output logic            alusrc0,
    output logic            aluop1,
    output logic            aluop0,
    output logic            memtoreg2,
    output logic            memtoreg1,
    output logic            memtoreg0,
    output logic            regtomem1,
    output logic            regtomem0,
    input  logic [OP_W-1:0] op
);

    ctrl_t ctrl_d;
    ctrl_t ctrl_q;

    control_decode u_decode (
        .op_i     (op),
        .ctrl_c_o (ctrl_d)
    );

    // Reset wins over decode so a reset edge always yields a NOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    assign memread   = ctrl_q.memread;
    assign memwrite  = ctrl_q.memwrite;
    assign regwrite  = ctrl_q.regwrite;
    assign regdest   = ctrl_q.regdest;
    assign branch    = ctrl_q.branch;
    assign jump      = ctrl_q.jump;
    assign alusrc1   = ctrl_q.alusrc[1];
    assign alusrc0   = ctrl_q.alusrc[0];
    assign aluop1    = ctrl_q.aluop[1];
    assign aluop0    = ctrl_q.aluop[0];
    assign memtoreg2 = ctrl_q.memtoreg[2];
    assign memtoreg1 = ctrl_q.memtoreg[1];
    assign memtoreg0 = ctrl_q.memtoreg[0];
    assign regtomem1 = ctrl_q.regtomem[1];
    assign regtomem0 = ctrl_q.regtomem[0];

endmodule

// File: tb/tb_control.sv
// Bench for the MIPS control unit: directed steps then random opcodes/resets against a table model.
module tb_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic memread, memwrite, regwrite, regdest, branch, jump;
    logic alusrc1, alusrc0, aluop1, aluop0;
    logic memtoreg2, memtoreg1, memtoreg0, regtomem1, regtomem0;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    control dut (
        .clk       (clk),
        .rst       (rst),
        .memread   (memread),
        .memwrite  (memwrite),
        .regwrite  (regwrite),
        .regdest   (regdest),
        .branch    (branch),
        .jump      (jump),
        .alusrc1   (alusrc1),
        .alusrc0   (alusrc0),
        .aluop1    (aluop1),
        .aluop0    (aluop0),
        .memtoreg2 (memtoreg2),
        .memtoreg1 (memtoreg1),
        .memtoreg0 (memtoreg0),
        .regtomem1 (regtomem1),
        .regtomem0 (regtomem0),
        .op        (op)
    );

    // Control word in table column order: mr mw rw rd br j alusrc aluop memtoreg regtomem.
    function automatic logic [14:0] model(input logic [5:0] o);
        case (o)
            6'b000000: return 15'b0_0_1_1_0_0_00_10_000_00;
            6'b100011: return 15'b1_0_1_0_0_0_01_00_001_00;
            6'b100000: return 15'b1_0_1_0_0_0_01_00_010_00;
            6'b100100: return 15'b1_0_1_0_0_0_01_00_011_00;
            6'b100001: return 15'b1_0_1_0_0_0_01_00_100_00;
            6'b100101: return 15'b1_0_1_0_0_0_01_00_101_00;
            6'b001111: return 15'b0_0_1_0_0_0_00_00_110_00;
            6'b101011: return 15'b0_1_0_0_0_0_01_00_000_00;
            6'b101000: return 15'b0_1_0_0_0_0_01_00_000_01;
            6'b101001: return 15'b0_1_0_0_0_0_01_00_000_10;
            6'b000100: return 15'b0_0_0_0_1_0_00_01_000_00;
            6'b000010: return 15'b0_0_0_0_0_1_00_00_000_00;
            default:   return 15'b0;
        endcase
    endfunction

    function automatic logic [14:0] observed();
        return {memread, memwrite, regwrite, regdest, branch, jump, alusrc1, alusrc0,
                aluop1, aluop0, memtoreg2, memtoreg1, memtoreg0, regtomem1, regtomem0};
    endfunction

    task automatic check(input string tag, input logic [14:0] exp);
        logic [14:0] obs;
        obs = observed();
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Apply op/rst, clock one edge, check the registered word, then wiggle op and confirm outputs hold.
    task automatic step(input logic [5:0] o, input logic r, input string tag);
        logic [14:0] exp;
        logic [5:0]  junk;
        op  = o;
        rst = r;
        exp = r ? 15'b0 : model(o);
        @(posedge clk);
        #1;
        check(tag, exp);
        tests++;
        assert (!(memread && memwrite) && !(branch && jump)) else begin
            failed++;
            $error("FAIL %s_excl: mr=%b mw=%b br=%b j=%b expected no overlap",
                   tag, memread, memwrite, branch, jump);
        end
        junk = 6'($urandom);
        op = junk;
        #2;
        check({tag, "_hold"}, exp);
    endtask

    logic [5:0] legal [12] = '{6'b000000, 6'b100011, 6'b100000, 6'b100100, 6'b100001, 6'b100101,
                               6'b001111, 6'b101011, 6'b101000, 6'b101001, 6'b000100, 6'b000010};

    initial begin
        logic [5:0] o;
        logic       r;
        rst = 1'b1;
        op  = 6'b000000;

        step(6'b000000, 1'b1, "rst_edge1");
        step(6'b000000, 1'b1, "rst_edge2");
        step(6'b000000, 1'b0, "rtype_after_rst");

        step(6'b100000, 1'b0, "lb");
        step(6'b100100, 1'b0, "lbu");
        step(6'b100001, 1'b0, "lh");
        step(6'b100101, 1'b0, "lhu");
        step(6'b001111, 1'b0, "lui");
        step(6'b100011, 1'b0, "lw");

        step(6'b101000, 1'b0, "sb");
        step(6'b101001, 1'b0, "sh");
        step(6'b101011, 1'b0, "sw");

        step(6'b000100, 1'b0, "beq");
        step(6'b000010, 1'b0, "j");

        step(6'b111111, 1'b0, "illegal_3f");
        step(6'b001000, 1'b0, "illegal_08");

        step(6'b101011, 1'b0, "sw_pre_rst");
        step(6'b101011, 1'b1, "sw_mid_rst");
        step(6'b101011, 1'b0, "sw_post_rst");

        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(3, 0) != 0) o = legal[$urandom_range(11, 0)];
            else                           o = 6'($urandom);
            r = ($urandom_range(15, 0) == 0);
            step(o, r, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/control.md
# control

Main control decoder of the single-cycle MIPS datapath. Takes the 6-bit instruction opcode and produces every datapath steering signal: memory read/write enables, register-file write and destination select, branch/jump flags, ALU source and ALU-op class, write-back source select and store-width select. Outputs are registered: decoded on the clock edge, with a synchronous reset to a safe all-zero (NOP) state.

## Interface
Parameters: none.
- clk  in  1  system clock, rising edge active
- rst  in  1  reset, synchronous, active-high
- memread  out  1  data-memory read enable
- memwrite  out  1  data-memory write enable
- regwrite  out  1  register-file write enable
- regdest  out  1  1 = write rd, 0 = write rt
- branch  out  1  beq branch candidate
- jump  out  1  unconditional jump
- alusrc1, alusrc0  out  1 each  ALU operand-B select: 00 = rt register, 01 = sign-extended immediate, 10/11 reserved
- aluop1, aluop0  out  1 each  ALU class: 00 = add, 01 = subtract, 10 = R-type (decode funct), 11 reserved
- memtoreg2..0  out  1 each  write-back source: 000 ALU, 001 lw word, 010 lb, 011 lbu, 100 lh, 101 lhu, 110 lui ({imm,16'b0}), 111 reserved
- regtomem1, regtomem0  out  1 each  store width: 00 word, 01 byte, 10 halfword, 11 reserved
- op  in  6  instruction opcode [31:26]

Port order: clk, rst, then the outputs in the order listed, then op.

## Operation
Decode, as (memread memwrite regwrite regdest branch jump alusrc aluop memtoreg regtomem):
- 000000 R-type: 0 0 1 1 0 0 00 10 000 00
- 100011 lw: 1 0 1 0 0 0 01 00 001 00
- 100000 lb: 1 0 1 0 0 0 01 00 010 00
- 100100 lbu: 1 0 1 0 0 0 01 00 011 00
- 100001 lh: 1 0 1 0 0 0 01 00 100 00
- 100101 lhu: 1 0 1 0 0 0 01 00 101 00
- 001111 lui: 0 0 1 0 0 0 00 00 110 00
- 101011 sw: 0 1 0 0 0 0 01 00 000 00
- 101000 sb: 0 1 0 0 0 0 01 00 000 01
- 101001 sh: 0 1 0 0 0 0 01 00 000 10
- 000100 beq: 0 0 0 0 1 0 00 01 000 00
- 000010 j: 0 0 0 0 0 1 00 00 000 00
- Any other opcode: all outputs 0 (NOP; no register or memory write).
- memread and memwrite never both 1; branch and jump never both 1; reserved encodings never produced.

## Timing
- All outputs registered; updated on rising clk from the op value sampled at that edge; latency 1 cycle.
- rst high at a rising edge: all outputs 0 at that edge, regardless of op; rst has priority over decode.
- Reset deassertion: first edge with rst low loads the decode of current op.
- op changing every cycle: each cycle's outputs reflect the previous edge's op; no hold, no internal state beyond the output register.
- Outputs are stable between edges; no combinational path from op to any output.

## Structure
- Shared package: opcode constants (OP_RTYPE, OP_LW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LUI, OP_SW, OP_SB, OP_SH, OP_BEQ, OP_J), ALU-src, ALU-op, memtoreg and regtomem encoding constants, consumed also by the datapath muxes.
- One sub-module: control_decode, purely combinational op -> 15-bit control word; the top is control_decode plus a 15-bit reset-to-zero register.

## Test plan
- rst=1 with op=000000 for 2 edges -> all outputs 0; release rst -> next edge regwrite=1, regdest=1, aluop=10.
- Sweep op 100000, 100100, 100001, 100101, 001111, 100011 -> memtoreg 010, 011, 100, 101, 110, 001; memread=1 except lui; regwrite=1, regdest=0.
- Sweep op 101000, 101001, 101011 -> memwrite=1, regwrite=0, alusrc=01, regtomem 01, 10, 00.
- op=000100 -> branch=1, aluop=01, alusrc=00; op=000010 -> jump=1, all other outputs 0.
- Illegal op 111111 and 001000 -> all outputs 0; op changed each cycle -> outputs lag exactly one edge; rst asserted mid-sequence (op=sw) -> memwrite 0 at that edge.
